// File: rtl/pid_pkg.sv
// Shared types and width helpers for the incremental PID compute path.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_P,
    MUL_I,
    MUL_D,
    ACC
  } state_t;

  localparam int PROD_XW = 2;
  localparam int SUM_XW  = 4;

  function automatic int prod_w(input int ew, input int kw);
    return ew + kw + PROD_XW;
  endfunction

  function automatic int sum_w(input int ew, input int kw);
    return ew + kw + SUM_XW;
  endfunction

endpackage

// File: rtl/pid_sat_clamp.sv
// Combinational clamp of a wide signed value into [OUT_MIN, OUT_MAX].
module pid_sat_clamp #(
  parameter int IN_W    = 37,
  parameter int OUT_W   = 16,
  parameter int OUT_MAX = 32767,
  parameter int OUT_MIN = -32768
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] HI = IN_W'(OUT_MAX);
  localparam logic signed [IN_W-1:0] LO = IN_W'(OUT_MIN);

  always_comb begin
    dout = OUT_W'(din);
    if (din > HI) begin
      dout = OUT_W'(HI);
    end else if (din < LO) begin
      dout = OUT_W'(LO);
    end
  end

endmodule

// File: rtl/pid_incr_calc.sv
// Incremental PID stage: one shared multiplier, three MAC cycles, accumulate.
// Define PID_OUT_SAT_EN to clamp u instead of wrapping it.
module pid_incr_calc
  import pid_pkg::*;
#(
  parameter int ERR_W   = 16,
  parameter int K_W     = 16,
  parameter int FRAC    = 8,
  parameter int OUT_W   = 16,
  parameter int OUT_MAX = 32767,
  parameter int OUT_MIN = -32768
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    clear,
  input  logic signed [ERR_W-1:0] ek0,
  input  logic signed [ERR_W-1:0] ek1,
  input  logic signed [ERR_W-1:0] ek2,
  input  logic signed [K_W-1:0]   kp,
  input  logic signed [K_W-1:0]   ki,
  input  logic signed [K_W-1:0]   kd,
  output logic signed [OUT_W-1:0] u,
  output logic                    done,
  output logic                    busy
);

  localparam int PW = prod_w(ERR_W, K_W);
  localparam int SW = sum_w(ERR_W, K_W);
  localparam int OW = ERR_W + 2;

  state_t state, state_nx;

  logic signed [ERR_W-1:0] e0_q;
  logic signed [ERR_W:0]   dp_q;
  logic signed [ERR_W+1:0] dd_q;
  logic signed [K_W-1:0]   kp_q, ki_q, kd_q;
  logic signed [SW-1:0]    sum_q, sum_nx;
  logic signed [K_W-1:0]   op_k;
  logic signed [OW-1:0]    op_e;
  logic signed [PW-1:0]    prod;
  logic signed [SW-1:0]    delta;
  logic signed [SW:0]      u_wide;
  logic signed [OUT_W-1:0] u_nx;
  logic                    accept;

  assign accept = (state == IDLE) && start && !clear;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = MUL_P;
      MUL_P:   state_nx = MUL_I;
      MUL_I:   state_nx = MUL_D;
      MUL_D:   state_nx = ACC;
      ACC:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  always_comb begin
    op_k = kp_q;
    op_e = OW'(dp_q);
    unique case (1'b1)
      (state == MUL_I): begin
        op_k = ki_q;
        op_e = OW'(e0_q);
      end
      (state == MUL_D): begin
        op_k = kd_q;
        op_e = dd_q;
      end
      default: ;
    endcase
  end

  assign prod   = PW'(op_k) * PW'(op_e);
  assign sum_nx = (state == MUL_P) ? SW'(prod)
                                   : sum_q + SW'(prod);
  assign delta  = sum_q >>> FRAC;
  assign u_wide = (SW+1)'(u) + (SW+1)'(delta);

`ifdef PID_OUT_SAT_EN
  pid_sat_clamp #(
    .IN_W   (SW + 1),
    .OUT_W  (OUT_W),
    .OUT_MAX(OUT_MAX),
    .OUT_MIN(OUT_MIN)
  ) u_clamp (
    .din (u_wide),
    .dout(u_nx)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (OUT_MAX > OUT_MIN);
  assign u_nx = OUT_W'(u_wide);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      dp_q  <= '0;
      dd_q  <= '0;
      kp_q  <= '0;
      ki_q  <= '0;
      kd_q  <= '0;
      sum_q <= '0;
      u     <= '0;
      done  <= 1'b0;
    end else if (clear) begin
      u    <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == ACC);
      if (accept) begin
        e0_q <= ek0;
        dp_q <= (ERR_W+1)'(ek0) - (ERR_W+1)'(ek1);
        dd_q <= (ERR_W+2)'(ek0) - ((ERR_W+2)'(ek1) <<< 1)
              + (ERR_W+2)'(ek2);
        kp_q <= kp;
        ki_q <= ki;
        kd_q <= kd;
      end
      if (state == MUL_P || state == MUL_I || state == MUL_D)
        sum_q <= sum_nx;
      if (state == ACC)
        u <= u_nx;
    end
  end

endmodule
